// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage handshake state and packed inter-stage payload bundles.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Decode-to-execute bundle, sized to exactly 128 bits so it fills the default skid payload.
  typedef struct packed {
    logic [15:0] ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rsvd;
    logic [31:0] pc;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } dec_ex_t;

  localparam int DEC_EX_W = $bits(dec_ex_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register between pipeline stages with flush squash, sticky halt and stall count.
module pipe_skid_reg
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state_q,     state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              main_halt_q, main_halt_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_halt_q, skid_halt_d;
  logic              halted_q,    halted_d;

  logic in_fire;
  logic out_fire;

  // Handshakes depend only on registered state so in_ready never sees out_ready or flush.
  assign in_ready  = (state_q != FULL) && !halted_q;
  assign out_valid = (state_q != EMPTY) && !halted_q;
  assign out_data  = main_data_q;
  assign out_halt  = main_halt_q;
  assign halted    = halted_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_halt_d = main_halt_q;
    skid_data_d = skid_data_q;
    skid_halt_d = skid_halt_q;
    halted_d    = halted_q;

    // A payload leaving during a flush still completes, so its halt tag counts.
    if (out_fire && main_halt_q) begin
      halted_d = 1'b1;
    end

    if (flush) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_halt_d = 1'b0;
      skid_data_d = '0;
      skid_halt_d = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_halt_d = in_halt;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_halt_d = in_halt;
          end else if (in_fire) begin
            state_d     = FULL;
            skid_data_d = in_data;
            skid_halt_d = in_halt;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_halt_d = skid_halt_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_halt_q <= 1'b0;
      skid_data_q <= '0;
      skid_halt_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_halt_q <= main_halt_d;
      skid_data_q <= skid_data_d;
      skid_halt_q <= skid_halt_d;
      halted_q    <= halted_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .CLK (CLK),
    .nRST(nRST),
    .inc (out_valid && !out_ready),
    .clr (1'b0),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: queue-based reference model, directed scenarios then random traffic.
module tb_pipe_skid_reg;
  import cpu_types_pkg::*;

  localparam int DW      = $bits(dec_ex_t);
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_halt;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_halt;
  logic          halted;
  logic [CW-1:0] stall_cnt;

  pipe_skid_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          h;
  } item_t;

  // Reference model: payloads held in arrival order, sticky halt, saturating stall count.
  item_t exp_q[$];
  bit    pend;
  bit    m_halted;
  int    m_stall;
  int    n_vec;
  int    n_bad;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle of stimulus; the accepted payload goes to the scoreboard.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit h, input bit ordy, input bit fl);
    in_valid  = v;
    in_data   = d;
    in_halt   = h;
    out_ready = ordy;
    flush     = fl;
    pend      = v && (exp_q.size() < 2) && !m_halted;
    if (pend) exp_q.push_back('{d: d, h: h});
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    pend     = 1'b0;
    m_halted = 1'b0;
    m_stall  = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    nRST     = 1'b0;
    model_clear();
    @(posedge CLK);
    #3;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    int  n;
    bit  mv;
    bit  mr;
    if (nRST) begin
      n  = exp_q.size() - int'(pend);
      mv = (n > 0) && !m_halted;
      mr = (n < 2) && !m_halted;
      check("out_valid", out_valid, mv);
      check("in_ready", in_ready, mr);
      check("halted", halted, m_halted);
      check("stall_cnt", stall_cnt, m_stall);
      if (mv) begin
        check("out_data", out_data, exp_q[0].d);
        check("out_halt", out_halt, exp_q[0].h);
      end
      if (mv && out_ready) begin
        if (exp_q[0].h) m_halted = 1'b1;
        void'(exp_q.pop_front());
      end
      if (mv && !out_ready && m_stall < CNT_MAX) m_stall++;
      if (flush) exp_q.delete();
      pend = 1'b0;
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_clear();
    nRST      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_halt   = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge CLK);
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_halt", out_halt, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_stall_cnt", stall_cnt, '0);
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Streaming at full rate
    cyc(1, DW'(8'hA), 0, 1, 0);
    cyc(1, DW'(8'hB), 0, 1, 0);
    cyc(1, DW'(8'hC), 0, 1, 0);
    repeat (3) cyc(0, '0, 0, 1, 0);

    // Backpressure: fill, hold 0x3 upstream, then drain in order
    cyc(1, DW'(8'h1), 0, 0, 0);
    cyc(1, DW'(8'h2), 0, 0, 0);
    repeat (3) cyc(1, DW'(8'h3), 0, 0, 0);
    repeat (2) cyc(1, DW'(8'h3), 0, 1, 0);
    repeat (3) cyc(0, '0, 0, 1, 0);

    // Flush while full with a coincident incoming payload
    cyc(1, DW'(8'h7), 0, 0, 0);
    cyc(1, DW'(8'h8), 0, 0, 0);
    cyc(1, DW'(8'h9), 0, 0, 1);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_out_data", out_data, '0);
    repeat (3) cyc(0, '0, 0, 1, 0);

    // Halt: 0x5 leaves and sets halted, 0x6 is refused, flush keeps halted
    cyc(1, DW'(8'h5), 1, 1, 0);
    cyc(0, '0, 0, 1, 0);
    repeat (3) cyc(1, DW'(8'h6), 0, 1, 0);
    cyc(0, '0, 0, 1, 1);
    cyc(0, '0, 0, 1, 0);
    check("halt_after_flush", halted, 1'b1);
    do_reset();

    // Stall saturation
    cyc(1, DW'(8'h44), 0, 0, 0);
    repeat (20) cyc(0, '0, 0, 0, 0);
    check("stall_saturated", stall_cnt, DW'(CNT_MAX));

    // Asynchronous reset between edges while one entry is held
    do_reset();
    cyc(1, DW'(8'h55), 1, 0, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    nRST = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, '0);
    check("arst_out_halt", out_halt, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_stall_cnt", stall_cnt, '0);
    model_clear();
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (m_halted && ($urandom_range(0, 7) == 0)) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 63) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      end
    end
    repeat (2) cyc(0, '0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
